// File: rtl/gcn_pkg.sv
// rtl/gcn_pkg.sv - shared state type, width defaults and row pack/unpack helpers for coo_aggregation (GCN_AGG_SELF_LOOP_EN adds the self-loop states)
package gcn_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 20;

    // Helpers work on a wide scratch bus so one definition serves any row geometry.
    localparam int ROW_BUS_MAX = 512;
    localparam int ELEM_MAX    = 64;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CLEAR      = 4'd1,
        ST_REQ_EDGE   = 4'd2,
        ST_LATCH_EDGE = 4'd3,
        ST_ACC_A      = 4'd4,
        ST_ACC_B      = 4'd5,
`ifdef GCN_AGG_SELF_LOOP_EN
        ST_SELF_REQ   = 4'd6,
        ST_SELF_ACC   = 4'd7,
`endif
        ST_STREAM     = 4'd8,
        ST_DONE       = 4'd9
    } agg_state_t;

    // Extract column col (col0 in LSBs) of a packed row, zero-extended.
    function automatic logic [ELEM_MAX-1:0] row_get(input logic [ROW_BUS_MAX-1:0] row,
                                                   input int col, input int width);
        logic [ELEM_MAX-1:0] mask;
        mask = {ELEM_MAX{1'b1}} >> (ELEM_MAX - width);
        return ELEM_MAX'(row >> (col * width)) & mask;
    endfunction

    // Replace column col of a packed row with the low width bits of val.
    function automatic logic [ROW_BUS_MAX-1:0] row_put(input logic [ROW_BUS_MAX-1:0] row,
                                                      input int col, input int width,
                                                      input logic [ELEM_MAX-1:0] val);
        logic [ROW_BUS_MAX-1:0] mask;
        mask = ROW_BUS_MAX'({ELEM_MAX{1'b1}} >> (ELEM_MAX - width)) << (col * width);
        return (row & ~mask) | ((ROW_BUS_MAX'(val) << (col * width)) & mask);
    endfunction

endpackage

// File: rtl/coo_agg_fsm.sv
// rtl/coo_agg_fsm.sv - sequencing FSM, edge/row counters and control strobes for coo_aggregation (GCN_AGG_SELF_LOOP_EN adds the self-loop pass)
module coo_agg_fsm
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS    = 6,
    parameter int NUM_EDGES       = 6,
    parameter int ROW_ADDR_WIDTH  = 3,
    parameter int EDGE_ADDR_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    input  logic                       out_ready_i,
    output logic [EDGE_ADDR_WIDTH-1:0] edge_cnt_o,
    output logic [ROW_ADDR_WIDTH-1:0]  row_cnt_o,
    output logic                       clear_o,
    output logic                       latch_o,
    output logic                       acc_a_o,
    output logic                       acc_b_o,
    output logic                       self_req_o,
    output logic                       self_acc_o,
    output logic                       stream_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam logic [EDGE_ADDR_WIDTH-1:0] LAST_EDGE = EDGE_ADDR_WIDTH'(NUM_EDGES - 1);
    localparam logic [ROW_ADDR_WIDTH-1:0]  LAST_ROW  = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [EDGE_ADDR_WIDTH-1:0] EDGE_ONE  = EDGE_ADDR_WIDTH'(1);
    localparam logic [ROW_ADDR_WIDTH-1:0]  ROW_ONE   = ROW_ADDR_WIDTH'(1);

    agg_state_t                 state_q, state_d;
    logic [EDGE_ADDR_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [ROW_ADDR_WIDTH-1:0]  row_cnt_q, row_cnt_d;

    // State and counter registers; reset returns to IDLE with counters cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            edge_cnt_q <= '0;
            row_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    // Next-state and counter update: fixed four cycles per edge, then optional self pass, then stream.
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        row_cnt_d  = row_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                edge_cnt_d = '0;
                row_cnt_d  = '0;
                state_d    = ST_REQ_EDGE;
            end
            ST_REQ_EDGE:   state_d = ST_LATCH_EDGE;
            ST_LATCH_EDGE: state_d = ST_ACC_A;
            ST_ACC_A:      state_d = ST_ACC_B;
            ST_ACC_B: begin
                if (edge_cnt_q == LAST_EDGE) begin
                    row_cnt_d = '0;
`ifdef GCN_AGG_SELF_LOOP_EN
                    state_d   = ST_SELF_REQ;
`else
                    state_d   = ST_STREAM;
`endif
                end else begin
                    edge_cnt_d = edge_cnt_q + EDGE_ONE;
                    state_d    = ST_REQ_EDGE;
                end
            end
`ifdef GCN_AGG_SELF_LOOP_EN
            ST_SELF_REQ: state_d = ST_SELF_ACC;
            ST_SELF_ACC: begin
                if (row_cnt_q == LAST_ROW) begin
                    row_cnt_d = '0;
                    state_d   = ST_STREAM;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_ONE;
                    state_d   = ST_SELF_REQ;
                end
            end
`endif
            ST_STREAM: begin
                if (out_ready_i) begin
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (start_i) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state only.
    always_comb begin
        clear_o    = 1'b0;
        latch_o    = 1'b0;
        acc_a_o    = 1'b0;
        acc_b_o    = 1'b0;
        self_req_o = 1'b0;
        self_acc_o = 1'b0;
        stream_o   = 1'b0;
        busy_o     = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_o     = (state_q == ST_DONE);
        edge_cnt_o = edge_cnt_q;
        row_cnt_o  = row_cnt_q;
        case (state_q)
            ST_CLEAR:      clear_o    = 1'b1;
            ST_LATCH_EDGE: latch_o    = 1'b1;
            ST_ACC_A:      acc_a_o    = 1'b1;
            ST_ACC_B:      acc_b_o    = 1'b1;
`ifdef GCN_AGG_SELF_LOOP_EN
            ST_SELF_REQ:   self_req_o = 1'b1;
            ST_SELF_ACC:   self_acc_o = 1'b1;
`endif
            ST_STREAM:     stream_o   = 1'b1;
            default:       ;
        endcase
    end

endmodule

// File: rtl/coo_aggregation.sv
// rtl/coo_aggregation.sv - COO edge-walk aggregation A*(F*W) with streamed row output (GCN_AGG_SELF_LOOP_EN gives (A+I)*(F*W))
module coo_aggregation
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int NUM_EDGES       = 6,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int ROW_ADDR_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int EDGE_ADDR_WIDTH = $clog2(NUM_EDGES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic [EDGE_ADDR_WIDTH-1:0]       coo_addr,
    input  logic [ROW_ADDR_WIDTH-1:0]        coo_src,
    input  logic [ROW_ADDR_WIDTH-1:0]        coo_dst,
    output logic [ROW_ADDR_WIDTH-1:0]        fm_wm_row_addr,
    input  logic [WEIGHT_COLS*DATA_WIDTH-1:0] fm_wm_row_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROW_ADDR_WIDTH-1:0]        out_row_addr,
    output logic [WEIGHT_COLS*ACC_WIDTH-1:0] out_row_data,
    output logic                             busy,
    output logic                             done
);

    localparam int ROW_W = WEIGHT_COLS * ACC_WIDTH;
    localparam logic [ROW_ADDR_WIDTH:0] ROW_LIMIT = (ROW_ADDR_WIDTH + 1)'(FEATURE_ROWS);

    logic [ROW_ADDR_WIDTH-1:0] row_cnt;
    logic clear_s, latch_s, acc_a_s, acc_b_s, self_req_s, self_acc_s, stream_s;

    logic [ROW_ADDR_WIDTH-1:0] src_q, dst_q;
    logic                      edge_ok_q;

    logic                      add_en;
    logic [ROW_ADDR_WIDTH-1:0] add_idx;
    logic [ROW_W-1:0]          acc_sel;
    logic [ACC_WIDTH-1:0]      col_sum [WEIGHT_COLS];
    logic [ROW_W-1:0]          sum_row;
    logic [ROW_W-1:0]          acc_q [FEATURE_ROWS];
    logic [ROW_W-1:0]          acc_d [FEATURE_ROWS];

    coo_agg_fsm #(
        .FEATURE_ROWS   (FEATURE_ROWS),
        .NUM_EDGES      (NUM_EDGES),
        .ROW_ADDR_WIDTH (ROW_ADDR_WIDTH),
        .EDGE_ADDR_WIDTH(EDGE_ADDR_WIDTH)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .out_ready_i(out_ready),
        .edge_cnt_o (coo_addr),
        .row_cnt_o  (row_cnt),
        .clear_o    (clear_s),
        .latch_o    (latch_s),
        .acc_a_o    (acc_a_s),
        .acc_b_o    (acc_b_s),
        .self_req_o (self_req_s),
        .self_acc_o (self_acc_s),
        .stream_o   (stream_s),
        .busy_o     (busy),
        .done_o     (done)
    );

    // Capture the edge endpoints and whether both are real nodes; padding edges contribute nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            edge_ok_q <= 1'b0;
        end else if (latch_s) begin
            src_q     <= coo_src;
            dst_q     <= coo_dst;
            edge_ok_q <= ({1'b0, coo_src} < ROW_LIMIT) && ({1'b0, coo_dst} < ROW_LIMIT);
        end
    end

    // Product-row address: the row read now is consumed by the add in the following state.
    always_comb begin
        fm_wm_row_addr = '0;
        if (latch_s)         fm_wm_row_addr = coo_dst;
        else if (acc_a_s)    fm_wm_row_addr = src_q;
        else if (self_req_s) fm_wm_row_addr = row_cnt;
    end

    // Select which accumulator row receives the incoming product row; self edges add only once.
    always_comb begin
        add_en  = 1'b0;
        add_idx = '0;
        if (acc_a_s) begin
            add_en  = edge_ok_q;
            add_idx = src_q;
        end else if (acc_b_s) begin
            add_en  = edge_ok_q && (src_q != dst_q);
            add_idx = dst_q;
        end else if (self_acc_s) begin
            add_en  = 1'b1;
            add_idx = row_cnt;
        end
        acc_sel = acc_q[add_idx];
    end

    // Per-column wrap-around sum of the selected accumulator and the zero-extended product element.
    always_comb begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            col_sum[c] = ACC_WIDTH'(row_get(ROW_BUS_MAX'(acc_sel), c, ACC_WIDTH))
                       + ACC_WIDTH'(row_get(ROW_BUS_MAX'(fm_wm_row_data), c, DATA_WIDTH));
        end
    end

    // Repack the column sums into one accumulator row.
    always_comb begin
        sum_row = '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            sum_row = ROW_W'(row_put(ROW_BUS_MAX'(sum_row), c, ACC_WIDTH, ELEM_MAX'(col_sum[c])));
        end
    end

    // Accumulator next state: cleared at the start of every run, else one row updated per add.
    always_comb begin
        acc_d = acc_q;
        if (clear_s) begin
            for (int r = 0; r < FEATURE_ROWS; r++) acc_d[r] = '0;
        end else if (add_en) begin
            acc_d[add_idx] = sum_row;
        end
    end

    // Accumulator storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < FEATURE_ROWS; r++) acc_q[r] <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Output stream: row_cnt only advances on acceptance, so addr/data hold while stalled.
    always_comb begin
        out_valid    = stream_s;
        out_row_addr = '0;
        out_row_data = '0;
        if (stream_s) begin
            out_row_addr = row_cnt;
            out_row_data = acc_q[row_cnt];
        end
    end

endmodule

// File: tb/tb_coo_aggregation.sv
// tb/tb_coo_aggregation.sv - self-checking bench for coo_aggregation (honours GCN_AGG_SELF_LOOP_EN)
`timescale 1ns/1ps
module tb_coo_aggregation;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int EDGES = 6;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int RAW = 3;
    localparam int EAW = 3;
`ifdef GCN_AGG_SELF_LOOP_EN
    localparam bit SELF_EN = 1'b1;
    localparam int EXP_LAT = 2 + 4 * EDGES + 2 * ROWS;
`else
    localparam bit SELF_EN = 1'b0;
    localparam int EXP_LAT = 2 + 4 * EDGES;
`endif

    logic clk = 1'b0;
    logic reset, start, out_ready, out_valid, busy, done;
    logic [EAW-1:0] coo_addr;
    logic [RAW-1:0] coo_src, coo_dst, fm_wm_row_addr, out_row_addr;
    logic [COLS*DW-1:0] fm_wm_row_data;
    logic [COLS*AW-1:0] out_row_data;

    int checks = 0;
    int failures = 0;

    logic [RAW-1:0] mem_src [8];
    logic [RAW-1:0] mem_dst [8];
    logic [DW-1:0]  prod [ROWS][COLS];
    logic [AW-1:0]  exp_acc [ROWS][COLS];

    typedef struct packed {
        logic [5:0][2:0] src;
        logic [5:0][2:0] dst;
        logic [5:0][7:0] k;      // expected row r = k[r] * {1,2,3} with P[i] = (i+1)*{1,2,3}
        logic [7:0]      stall_row;
        logic [7:0]      stall_cyc;
    } vec_t;
    vec_t vecs [3];

    always #5 clk = ~clk;

    coo_aggregation dut (
        .clk(clk), .reset(reset), .start(start),
        .coo_addr(coo_addr), .coo_src(coo_src), .coo_dst(coo_dst),
        .fm_wm_row_addr(fm_wm_row_addr), .fm_wm_row_data(fm_wm_row_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row_addr(out_row_addr), .out_row_data(out_row_data),
        .busy(busy), .done(done)
    );

    function automatic logic [COLS*DW-1:0] prod_row(input logic [RAW-1:0] a);
        logic [COLS*DW-1:0] r;
        r = '0;
        if (int'(a) < ROWS)
            for (int c = 0; c < COLS; c++) r[c*DW +: DW] = prod[a][c];
        return r;
    endfunction

    function automatic logic [COLS*AW-1:0] exp_row(input int r);
        logic [COLS*AW-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*AW +: AW] = exp_acc[r][c];
        return v;
    endfunction

    // Registered COO and product memories: data one cycle after the address.
    always @(posedge clk) begin
        coo_src        <= mem_src[coo_addr];
        coo_dst        <= mem_dst[coo_addr];
        fm_wm_row_data <= prod_row(fm_wm_row_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic load_vec(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                prod[r][c] = DW'((r + 1) * (c + 1));
                exp_acc[r][c] = AW'(int'(vecs[v].k[r]) * (c + 1) + (SELF_EN ? (r + 1) * (c + 1) : 0));
            end
        for (int e = 0; e < 8; e++) begin
            mem_src[e] = (e < EDGES) ? vecs[v].src[e] : 3'd7;
            mem_dst[e] = (e < EDGES) ? vecs[v].dst[e] : 3'd7;
        end
    endtask

    // Reference: each real edge adds each endpoint's product into the other, self edges once.
    task automatic build_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_acc[r][c] = SELF_EN ? AW'(prod[r][c]) : '0;
        for (int e = 0; e < EDGES; e++) begin
            int s, d;
            s = int'(mem_src[e]);
            d = int'(mem_dst[e]);
            if (s < ROWS && d < ROWS) begin
                for (int c = 0; c < COLS; c++) begin
                    exp_acc[s][c] = exp_acc[s][c] + AW'(prod[d][c]);
                    if (s != d) exp_acc[d][c] = exp_acc[d][c] + AW'(prod[s][c]);
                end
            end
        end
    endtask

    task automatic run_check(input string nm, input int stall_row, input int stall_cyc, input int pulse_at);
        int n, got, stall_left, guard;
        bit held_v;
        logic [RAW-1:0] h_addr;
        logic [COLS*AW-1:0] h_data;
        logic [RAW-1:0] got_addr [ROWS];
        logic [COLS*AW-1:0] got_data [ROWS];
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, " cycle1 busy/done"}, {62'd0, busy, done}, 64'b10);
        n = 1;
        while (!out_valid && n < 200) begin
            start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({nm, " first valid cycle"}, 64'(n), 64'(EXP_LAT));
        got = 0; stall_left = stall_cyc; guard = 0; held_v = 0; h_addr = '0; h_data = '0;
        while (got < ROWS && guard < 200) begin
            if (out_valid) begin
                if (int'(out_row_addr) == stall_row && stall_left > 0) begin
                    out_ready = 1'b0;
                    if (held_v) chk({nm, " stall hold"}, {1'b0, out_row_addr, out_row_data}, {1'b0, h_addr, h_data});
                    held_v = 1; h_addr = out_row_addr; h_data = out_row_data;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                    if (held_v) chk({nm, " stall release"}, {1'b0, out_row_addr, out_row_data}, {1'b0, h_addr, h_data});
                    held_v = 0;
                    got_addr[got] = out_row_addr;
                    got_data[got] = out_row_data;
                    got++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        chk({nm, " rows streamed"}, 64'(got), 64'(ROWS));
        chk({nm, " done state"}, {61'd0, done, busy, out_valid}, 64'b100);
        for (int i = 0; i < got; i++) begin
            chk($sformatf("%s row%0d addr", nm, i), 64'(got_addr[i]), 64'(i));
            chk($sformatf("%s row%0d data", nm, i), 64'(got_data[i]), 64'(exp_row(i)));
        end
    endtask

    initial begin
        // Test plan scenario 1: (0,1) plus padding
        vecs[0].src = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
        vecs[0].dst = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1};
        vecs[0].k   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
        vecs[0].stall_row = 8'hFF; vecs[0].stall_cyc = 8'd0;
        // Scenario 2: self edge on node 2, added once
        vecs[1].src = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd2};
        vecs[1].dst = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd2};
        vecs[1].k   = {8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0};
        vecs[1].stall_row = 8'hFF; vecs[1].stall_cyc = 8'd0;
        // Scenario 3: ring 0-1-2-3-4-5-0, row r = P[r-1] + P[r+1]; stall 3 cycles on row 1
        vecs[2].src = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        vecs[2].dst = {3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        vecs[2].k   = {8'd6, 8'd10, 8'd8, 8'd6, 8'd4, 8'd8};
        vecs[2].stall_row = 8'd1; vecs[2].stall_cyc = 8'd3;

        reset = 1'b0; start = 1'b0; out_ready = 1'b0;
        load_vec(0);
        #1 reset = 1'b1;
        #1;
        chk("reset outputs", {29'd0, coo_addr, fm_wm_row_addr, out_valid, out_row_addr, busy, done},
            64'd0);
        chk("reset row data", 64'(out_row_data), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            run_check($sformatf("vec%0d", v), int'(vecs[v].stall_row), int'(vecs[v].stall_cyc), -1);
        end

        // Reset in the middle of edge 3, then a clean rerun of the ring
        load_vec(2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrun busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrun reset outputs", {29'd0, coo_addr, fm_wm_row_addr, out_valid, out_row_addr, busy, done},
            64'd0);
        chk("midrun reset row data", 64'(out_row_data), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", {62'd0, busy, done}, 64'd0);
        run_check("after reset", 1, 3, -1);

        // start pulsed while busy is ignored; then restart straight from DONE
        run_check("busy pulse", -1, 0, 10);
        run_check("rerun from done", 4, 2, -1);

        // Randomized graphs and products against the reference model
        for (int it = 0; it < 20; it++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) prod[r][c] = DW'($urandom);
            for (int e = 0; e < 8; e++) begin
                mem_src[e] = RAW'($urandom_range(0, 7));
                mem_dst[e] = ($urandom_range(0, 3) == 0) ? mem_src[e] : RAW'($urandom_range(0, 7));
            end
            build_model();
            run_check($sformatf("rand%0d", it), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coo_aggregation.md
Name: coo_aggregation

Overview:
Combination stage directly downstream of the feature×weight transformation stage. It walks the COO edge list of an undirected graph. For each edge it adds each endpoint's FM_WM product row into the other endpoint's accumulator row, computing A·(F·W). When the walk finishes, it streams the aggregated rows out with a valid/ready handshake for the argmax/output stage.

Parameters:
FEATURE_ROWS, 6, number of nodes (rows of the FM_WM product)
WEIGHT_COLS, 3, columns per product row
NUM_EDGES, 6, entries in the COO memory
DATA_WIDTH, 16, unsigned width of one product element
ACC_WIDTH, 20, unsigned width of one accumulator element
ROW_ADDR_WIDTH, $clog2(FEATURE_ROWS), node index width
EDGE_ADDR_WIDTH, $clog2(NUM_EDGES), COO address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  begin aggregation (driven by the transformation stage's done)
coo_addr  out  EDGE_ADDR_WIDTH  COO memory read address
coo_src  in  ROW_ADDR_WIDTH  edge endpoint A, valid 1 cycle after coo_addr
coo_dst  in  ROW_ADDR_WIDTH  edge endpoint B, valid 1 cycle after coo_addr
fm_wm_row_addr  out  ROW_ADDR_WIDTH  product memory row address
fm_wm_row_data  in  WEIGHT_COLS*DATA_WIDTH  product row (col0 in LSBs), valid 1 cycle after address
out_valid  out  1  aggregated row available
out_ready  in  1  consumer accepts the row
out_row_addr  out  ROW_ADDR_WIDTH  index of the streamed row
out_row_data  out  WEIGHT_COLS*ACC_WIDTH  aggregated row (col0 in LSBs)
busy  out  1  high in every state except IDLE and DONE
done  out  1  aggregation and streaming complete

Behaviour:
- Reset, asynchronous, takes effect at any time including mid-run:
  - state goes to IDLE
  - all outputs, counters and accumulators go to 0
- States:
  - IDLE: wait; start -> CLEAR.
  - CLEAR: zero all accumulators; edge_cnt=0 -> REQ_EDGE.
  - REQ_EDGE: coo_addr=edge_cnt -> LATCH_EDGE.
  - LATCH_EDGE: register src_q/dst_q from coo_src/coo_dst; fm_wm_row_addr=coo_dst (combinational) -> ACC_A.
  - ACC_A: acc[src_q] += P[dst_q]; fm_wm_row_addr=src_q -> ACC_B.
  - ACC_B: acc[dst_q] += P[src_q]. If edge_cnt==NUM_EDGES-1 -> SELF_REQ (macro) or STREAM. Otherwise edge_cnt++ and -> REQ_EDGE.
  - STREAM: out_valid=1, out_row_addr=row_cnt, out_row_data=acc[row_cnt]. On out_valid&&out_ready, row_cnt++. After the last row is accepted -> DONE.
  - DONE: done=1, held. start -> CLEAR (done drops the next cycle). Otherwise stay.
- Fixed timing: 4 cycles per edge regardless of edge content.
  - Start sampled in cycle 0; CLEAR is cycle 1.
  - First out_valid in cycle 2+4*NUM_EDGES (without macro).
- Edge boundary cases:
  - Self edge (src==dst): the row is added once. The ACC_B add is suppressed; ACC_B still occupies its cycle.
  - Out-of-range index (≥FEATURE_ROWS) on either endpoint: the whole edge is ignored (no add); timing unchanged. Used for padding.
- Arithmetic: elements are zero-extended to ACC_WIDTH; additions wrap modulo 2^ACC_WIDTH with no saturation.
- Handshake: while out_valid && !out_ready, out_row_addr and out_row_data hold stable. out_valid never drops before acceptance.
- start is ignored while busy.

Optional Feature:
Macro GCN_AGG_SELF_LOOP_EN.
- Defined: after the last edge, the FSM runs SELF_REQ (fm_wm_row_addr=row_cnt) then SELF_ACC (acc[row_cnt] += P[row_cnt]) for every row, giving (A+I)·FW. row_cnt is reset to 0 before STREAM. This adds 2*FEATURE_ROWS cycles.
- Undefined: the SELF states do not exist; ACC_B goes directly to STREAM.

Decomposition:
- Shared package gcn_pkg holds:
  - agg_state_t enum
  - DATA_WIDTH/ACC_WIDTH defaults
  - row pack/unpack helper functions
- One sub-module, coo_agg_fsm: state register, edge/row counters, control strobes.
- Accumulator array and adders stay in the top level.

Test Plan:
All scenarios use defaults with P[i]={i+1, 2(i+1), 3(i+1)}.
1. Edges {(0,1), (7,7)×5} -> row0={2,4,6}, row1={1,2,3}, rows 2–5 zero; first out_valid in cycle 26 after start.
2. Edges {(2,2), (7,7)×5} -> row2={3,6,9} (added once), all other rows zero.
3. Full ring (0,1),(1,2),...,(5,0) -> row0=P1+P5={8,16,24}, row3=P2+P4={8,16,24}; out_ready held low 3 cycles on row 1 -> row 1 stays stable, no row skipped or duplicated.
4. Reset asserted during edge 3 -> all outputs 0 and state IDLE the same cycle; a fresh start gives the scenario-3 result exactly (accumulators re-cleared).
5. start pulsed while busy -> ignored, result unchanged. start in DONE -> done low next cycle, rerun produces identical rows.
6. GCN_AGG_SELF_LOOP_EN with edges {(0,1), pad×5} -> row0={3,6,9}, row1={3,6,9}, row2={3,6,9}; first out_valid in cycle 38.
